// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder, oversampled in the system clock domain.
// Define SPI_REG_AUTOINC_EN for burst mode (address increments after each data byte).
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_active
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state, state_nxt;
  logic              cs_p0, cs_p1;
  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              mosi_p0, mosi_p1;
  logic              armed;
  logic              sclk_rise, sclk_fall, byte_done;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sh, tx_sh, rx_byte;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic              is_write, byte_used;
  logic [7:0]        regfile [NREG];

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sh[6:0], mosi_p1};
  assign addr_inc  = addr + ADDR_W'(1);

  // Pin synchronisers and SCLK edge history. CS syncs reset low so a CS already
  // low at reset release never looks like a fresh frame; armed waits for CS high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      armed   <= 1'b0;
    end else begin
      cs_p0   <= CS;
      cs_p1   <= cs_p0;
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= MOSI;
      mosi_p1 <= mosi_p0;
      if (cs_p1) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (armed && !cs_p1) state_nxt = CMD;
      CMD:     if (cs_p1) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (cs_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, register file and output ports
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= 3'd0;
      rx_sh        <= 8'd0;
      tx_sh        <= 8'd0;
      addr         <= '0;
      is_write     <= 1'b0;
      byte_used    <= 1'b0;
      MISO         <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'd0;
      loc_rdata    <= 8'd0;
      frame_active <= 1'b0;
      for (int i = 0; i < NREG; i++) regfile[i] <= 8'd0;
    end else begin
      wr_strobe    <= 1'b0;
      loc_rdata    <= regfile[loc_addr];
      frame_active <= (state_nxt != IDLE);
      if (cs_p1 || state == IDLE) begin
        bit_cnt   <= 3'd0;
        tx_sh     <= 8'd0;
        MISO      <= 1'b0;
        byte_used <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sh   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sclk_fall) begin
          MISO  <= tx_sh[7];
          tx_sh <= {tx_sh[6:0], 1'b0};
        end
        if (byte_done) begin
          if (state == CMD) begin
            is_write <= rx_byte[7];
            addr     <= rx_byte[ADDR_W-1:0];
            tx_sh    <= rx_byte[7] ? 8'd0 : regfile[rx_byte[ADDR_W-1:0]];
          end else begin
            if (is_write && !byte_used) begin
              regfile[addr] <= rx_byte;
              wr_strobe     <= 1'b1;
              wr_addr       <= addr;
              wr_data       <= rx_byte;
            end
`ifdef SPI_REG_AUTOINC_EN
            addr  <= addr_inc;
            tx_sh <= is_write ? 8'd0 : regfile[addr_inc];
`else
            // Only the first data byte counts; later bytes shift out zeros.
            byte_used <= 1'b1;
            tx_sh     <= 8'd0;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed plus randomized bench for spi_reg_slave with an array-based register model.
`timescale 1ns/1ps
module tb_spi_reg_slave;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
  localparam int HALF   = 80;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              CS = 1'b1;
  logic              SCLK = 1'b0;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic [ADDR_W-1:0] loc_addr = '0;
  logic [7:0]        loc_rdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_active;

  always #5 clk = ~clk;

  spi_reg_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_active(frame_active)
  );

  int                n_checks = 0;
  int                n_pass = 0;
  logic [7:0]        model [NREG];
  logic [7:0]        mbytes [8];
  logic [7:0]        sbytes [8];
  int                cmd_miso_ones;
  logic [ADDR_W-1:0] sq_a [$];
  logic [7:0]        sq_d [$];
  logic              pend = 1'b0;
  logic [7:0]        pend_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe collector; also checks the same-cycle old/new loc_rdata behaviour.
  always @(negedge clk) begin
    if (pend) begin
      check("loc_new_after_wr", loc_rdata, pend_d);
      pend = 1'b0;
    end
    if (wr_strobe) begin
      sq_a.push_back(wr_addr);
      sq_d.push_back(wr_data);
      if (wr_addr == loc_addr) begin
        check("loc_old_during_wr", loc_rdata, model[loc_addr]);
        pend   = 1'b1;
        pend_d = wr_data;
      end
    end
  end

  task automatic spi_bits(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      MOSI = mbytes[i/8][7-(i%8)];
      #HALF;
      SCLK = 1'b1;
      sbytes[i/8][7-(i%8)] = MISO;
      if (i < 8 && MISO !== 1'b0) cmd_miso_ones++;
      #HALF;
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int nbits);
    for (int i = 0; i < 8; i++) sbytes[i] = 8'h00;
    cmd_miso_ones = 0;
    CS = 1'b0;
    #HALF;
    check("frame_active_hi", frame_active, 1);
    spi_bits(0, nbits);
    MOSI = 1'b0;
    #HALF;
    CS = 1'b1;
    #(4*HALF);
    check("frame_active_lo", frame_active, 0);
  endtask

  task automatic sweep_loc();
    for (int a = 0; a < NREG; a++) begin
      @(negedge clk) loc_addr = ADDR_W'(a);
      @(negedge clk);
      check($sformatf("loc_rdata[%0d]", a), loc_rdata, model[a]);
    end
  endtask

  // Frame = command byte + whole data bytes; trailing partial bits are discarded.
  task automatic run_frame(input int nbits);
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] exp_a [8];
    logic [7:0]        exp_d [8];
    int                nd, exp_n;
    bit                used;
    cmd = mbytes[0];
    nd  = (nbits >= 8) ? (nbits - 8) / 8 : 0;
    spi_xfer(nbits);
    check("miso_cmd_zero", cmd_miso_ones, 0);
    exp_n = 0;
    for (int k = 0; k < nd; k++) begin
      a    = cmd[ADDR_W-1:0] + ADDR_W'(k);
      used = AUTOINC || (k == 0);
      if (cmd[7]) begin
        check($sformatf("miso_wr_byte%0d", k), sbytes[k+1], 0);
        if (used) begin
          exp_a[exp_n] = a;
          exp_d[exp_n] = mbytes[k+1];
          exp_n++;
        end
      end else begin
        check($sformatf("rd_byte%0d_a%0d", k, a), sbytes[k+1], used ? model[a] : 8'h00);
      end
    end
    check("strobe_count", sq_a.size(), exp_n);
    for (int i = 0; i < exp_n && i < sq_a.size(); i++) begin
      check("wr_addr", sq_a[i], exp_a[i]);
      check("wr_data", sq_d[i], exp_d[i]);
      model[exp_a[i]] = exp_d[i];
    end
    sq_a.delete();
    sq_d.delete();
    sweep_loc();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    for (int i = 0; i < 8; i++) mbytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_active", frame_active, 0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single write to addr 3, watched on the local port at the same time
    @(negedge clk) loc_addr = 3'd3;
    mbytes[0] = 8'h83; mbytes[1] = 8'h5A;
    run_frame(16);

    mbytes[0] = 8'h03;
    run_frame(16);

    // Write aborted after 4 data bits
    mbytes[0] = 8'h85; mbytes[1] = 8'hC3;
    run_frame(12);

    // Burst wrapping 7 -> 0 (single byte without autoinc)
    mbytes[0] = 8'h87; mbytes[1] = 8'h11; mbytes[2] = 8'h22;
    run_frame(24);
    mbytes[0] = 8'h07;
    run_frame(24);

    // Async reset in the middle of a read of 0xFF
    mbytes[0] = 8'h86; mbytes[1] = 8'hFF;
    run_frame(16);
    mbytes[0] = 8'h06; mbytes[1] = 8'h00;
    CS = 1'b0;
    #HALF;
    spi_bits(0, 9);
    #(HALF/2);
    check("miso_before_rst", MISO, 1);
    #3 reset = 1'b0;
    #1;
    check("miso_async_rst", MISO, 0);
    check("frame_active_async_rst", frame_active, 0);
    check("loc_rdata_async_rst", loc_rdata, 0);
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    mbytes[0] = 8'h81; mbytes[1] = 8'hAA;
    spi_bits(0, 16);
    check("cs_low_at_release_ignored", frame_active, 0);
    check("no_strobe_after_release", sq_a.size(), 0);
    check("miso_after_release", MISO, 0);
    CS = 1'b1;
    MOSI = 1'b0;
    #(4*HALF);
    sweep_loc();
    mbytes[0] = 8'h03;
    run_frame(16);

    // Randomized back-to-back frames
    for (int it = 0; it < 20; it++) begin
      int nb, extra;
      for (int i = 0; i < 4; i++) mbytes[i] = 8'($urandom);
      nb    = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(8 + 8*nb + extra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
